// File: rtl/bsc_ibus_arbiter.sv
// Two-master arbiter in front of the BSC IBUS port: CPU data port (C) vs DMAC (D).
// Grants one owner per beat (fixed or round-robin), honours LOCK up to LOCK_MAX beats.
module bsc_ibus_arbiter #(
    parameter logic [1:0] PRIO     = 2'd2,
    parameter int         LOCK_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        RES_N,
    input  logic [31:0] C_A,
    input  logic [31:0] C_DI,
    input  logic [3:0]  C_BA,
    input  logic        C_WE,
    input  logic        C_REQ,
    input  logic        C_LOCK,
    output logic [31:0] C_DO,
    output logic        C_BUSY,
    input  logic [31:0] D_A,
    input  logic [31:0] D_DI,
    input  logic [3:0]  D_BA,
    input  logic        D_WE,
    input  logic        D_REQ,
    input  logic        D_LOCK,
    output logic [31:0] D_DO,
    output logic        D_BUSY,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    output logic        IBUS_LOCK,
    input  logic [31:0] IBUS_DO,
    input  logic        IBUS_BUSY,
    output logic [1:0]  OWNER
);

    // Encoding doubles as the OWNER status code.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_C = 2'b01,
        OWN_D = 2'b10
    } state_e;

    localparam logic LAST_C = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_e     state_q, state_d;
    logic       seen_q, seen_d;
    logic       last_q, last_d;
    logic [3:0] lcnt_q, lcnt_d;

    logic own_c, own_d;
    logic own_req, own_lock, oth_req;
    logic pick_d;
    logic under_cap;

    assign own_c = (state_q == OWN_C);
    assign own_d = (state_q == OWN_D);
    assign OWNER = state_q;

    assign C_DO = IBUS_DO;
    assign D_DO = IBUS_DO;

    assign C_BUSY = (C_REQ & ~own_c) | (own_c & IBUS_BUSY);
    assign D_BUSY = (D_REQ & ~own_d) | (own_d & IBUS_BUSY);

    assign own_req  = own_c ? C_REQ  : D_REQ;
    assign own_lock = own_c ? C_LOCK : D_LOCK;
    assign oth_req  = own_c ? D_REQ  : C_REQ;

    // Tie-break: round-robin hands the bus to whoever did not finish the last beat.
    always_comb begin
        case (PRIO)
            2'd0:    pick_d = 1'b0;
            2'd1:    pick_d = 1'b1;
            default: pick_d = ~last_q;
        endcase
    end

    assign under_cap = (LOCK_MAX == 0) || (int'(lcnt_q) < LOCK_MAX - 1);

    always_comb begin
        IBUS_A    = '0;
        IBUS_DI   = '0;
        IBUS_BA   = '0;
        IBUS_WE   = 1'b0;
        IBUS_REQ  = 1'b0;
        IBUS_LOCK = 1'b0;
        case (state_q)
            OWN_C: begin
                IBUS_A    = C_A;
                IBUS_DI   = C_DI;
                IBUS_BA   = C_BA;
                IBUS_WE   = C_WE;
                IBUS_REQ  = C_REQ;
                IBUS_LOCK = C_LOCK;
            end
            OWN_D: begin
                IBUS_A    = D_A;
                IBUS_DI   = D_DI;
                IBUS_BA   = D_BA;
                IBUS_WE   = D_WE;
                IBUS_REQ  = D_REQ;
                IBUS_LOCK = D_LOCK;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        last_d  = last_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            IDLE: begin
                if (C_REQ && D_REQ) state_d = pick_d ? OWN_D : OWN_C;
                else if (C_REQ)     state_d = OWN_C;
                else if (D_REQ)     state_d = OWN_D;
            end
            OWN_C, OWN_D: begin
                if (!seen_q) begin
                    if (IBUS_BUSY) begin
                        seen_d = 1'b1;
                    end else if (!own_req) begin
                        // Cancelled before BSC accepted: no beat happened, LAST kept.
                        state_d = IDLE;
                        lcnt_d  = '0;
                    end
                end else if (!IBUS_BUSY) begin
                    seen_d = 1'b0;
                    last_d = own_d ? LAST_D : LAST_C;
                    if (own_lock && (!oth_req || under_cap)) begin
                        lcnt_d = (lcnt_q == 4'hF) ? lcnt_q : lcnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        lcnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!RES_N) begin
            state_d = IDLE;
            seen_d  = 1'b0;
            last_d  = LAST_C;
            lcnt_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            seen_q  <= 1'b0;
            last_q  <= LAST_C;
            lcnt_q  <= '0;
        end else if (CE_R) begin
            state_q <= state_d;
            seen_q  <= seen_d;
            last_q  <= last_d;
            lcnt_q  <= lcnt_d;
        end
    end

endmodule
